router_fsm_ctrl: RTL and testbench
==================================

// Module: router_fsm_ctrl
// PURPOSE
// - Packet-level control FSM of the 1x3 router; sits upstream of the three output FIFOs and the input register.
// - Decodes the header address, sequences header/payload/parity loading, stalls on full, and waits on a busy destination.
// - Drives lfd_state and the FIFO write strobe (write_enb_reg) consumed by the FIFO stage.
// PARAMETERS
// - NUM_PORTS  3   number of destination FIFOs; valid address range is 0..NUM_PORTS-1
// - ADDR_W     2   width of the header address field data_in[1:0]
// - TIMEOUT    30  WAIT_TILL_EMPTY watchdog limit in cycles; used only with ROUTER_FSM_TIMEOUT_EN
// PORTS
// - clk            in   1          rising-edge clock
// - rst            in   1          asynchronous, active-low reset
// - pkt_valid      in   1          source is driving packet bytes
// - data_in        in   ADDR_W     header address bits, sampled in DECODE_ADDRESS
// - parity_done    in   1          parity byte has been captured by the register stage
// - low_pkt_valid  in   1          pkt_valid dropped while stalled
// - fifo_full      in   1          selected destination FIFO is full
// - fifo_empty     in   NUM_PORTS  per-FIFO empty flags
// - soft_rst       in   NUM_PORTS  per-FIFO soft reset (read timeout)
// - busy           out  1          source must hold data
// - detect_add, lfd_state, ld_state, laf_state, full_state  out 1  one-hot state decodes
// - write_enb_reg  out  1          FIFO write enable
// - rst_int_reg    out  1          clears internal parity in register stage
// - drop_pkt       out  1          single-cycle pulse: packet abandoned by watchdog
// BEHAVIOUR
// - Reset: state=DECODE_ADDRESS, addr_q=0 -> detect_add=1, all other outputs 0. Reset mid-packet aborts immediately.
// - All outputs are Moore decodes of the state register (zero-latency from state, one cycle from inputs).
// - addr_q is latched from data_in when DECODE_ADDRESS && pkt_valid && data_in<NUM_PORTS.
// - Transitions:
//   DECODE_ADDRESS: pkt_valid && addr valid && fifo_empty[data_in] -> LOAD_FIRST_DATA.
//                   pkt_valid && addr valid && !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
//                   Else stay (address 3 is ignored; the packet is dropped).
//   LOAD_FIRST_DATA -> LOAD_DATA (unconditional).
//   LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
//   FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//   LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS.
//                    !parity_done && low_pkt_valid -> LOAD_PARITY.
//                    !parity_done && !low_pkt_valid -> LOAD_DATA.
//   LOAD_PARITY -> CHECK_PARITY_ERROR.
//   CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
//   WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
// - soft_rst[addr_q] in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle; overrides all other conditions.
// - Output decodes:
//   busy = 1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
//   write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
//   rst_int_reg = CHECK_PARITY_ERROR.
// - Simultaneous fifo_full and !pkt_valid in LOAD_DATA: full wins (no byte lost).
// CONFIGURATION
// - ROUTER_FSM_TIMEOUT_EN defined:
//   - 5-bit watchdog counts cycles spent in WAIT_TILL_EMPTY; it clears on entry.
//   - At count==TIMEOUT-1 with fifo_empty[addr_q]=0, the FSM goes to DECODE_ADDRESS and pulses drop_pkt for 1 cycle.
//   - fifo_empty on the same cycle wins (go to LOAD_FIRST_DATA, no drop).
// - Undefined: WAIT_TILL_EMPTY waits indefinitely; drop_pkt is tied 0; no counter is instantiated.
// STRUCTURE
// - Package router_pkg holds: state encodings (8 localparams, 3-bit), ADDR_W, NUM_PORTS, ADDR_INVALID=2'b11.
// - Sub-module router_fsm_timer (watchdog counter) exists only under ROUTER_FSM_TIMEOUT_EN; everything else stays flat.
// TESTING
// - rst=0 for 2 cycles -> detect_add=1, busy=0, write_enb_reg=0.
// - Normal packet: header 8'h0D (len 3, addr 1) with fifo_empty=3'b111.
//   -> LFD for 1 cycle, LOAD_DATA 3 cycles, LOAD_PARITY, CHECK_PARITY_ERROR, then DECODE_ADDRESS.
// - fifo_full=1 during payload byte 2 -> FIFO_FULL_STATE, busy=1, write_enb_reg=0.
//   Release full with pkt_valid=1 -> LOAD_AFTER_FULL -> LOAD_DATA.
// - Header addr 2 with fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1.
//   Raise fifo_empty[2] at cycle 5 -> LOAD_FIRST_DATA next cycle.
// - soft_rst[1]=1 in LOAD_DATA (addr 1) -> DECODE_ADDRESS next cycle; soft_rst[0] has no effect.
//   Header 8'h03 (addr 3) -> stays in DECODE_ADDRESS.
// - With ROUTER_FSM_TIMEOUT_EN: fifo_empty[0]=0 held for 30 cycles in WAIT_TILL_EMPTY.
//   -> drop_pkt=1 for 1 cycle, state=DECODE_ADDRESS.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and state encoding for the 1x3 router control path.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam int TIMEOUT   = 30;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

endpackage

// File: rtl/router_fsm_timer.sv
// Watchdog for WAIT_TILL_EMPTY; only built when ROUTER_FSM_TIMEOUT_EN is defined.
`ifdef ROUTER_FSM_TIMEOUT_EN
module router_fsm_timer
  import router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  output logic expired
);

  localparam logic [4:0] LIMIT = 5'(TIMEOUT - 1);

  logic [4:0] count_reg;

  // Held at zero outside the wait state so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (!in_wait) begin
      count_reg <= '0;
    end else if (count_reg != LIMIT) begin
      count_reg <= count_reg + 5'd1;
    end
  end

  assign expired = in_wait && (count_reg == LIMIT);

endmodule
`endif

// File: rtl/router_fsm_ctrl.sv
// Packet-level control FSM of the 1x3 router (header decode, load sequencing, full stall).
// Optional WAIT_TILL_EMPTY watchdog with drop_pkt pulse: define ROUTER_FSM_TIMEOUT_EN.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int ADDR_W    = router_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 drop_pkt
);

  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              addr_ok;

  assign addr_ok = ({1'b0, data_in} < PORT_LIMIT) && (data_in != ADDR_INVALID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE_ADDRESS && pkt_valid && addr_ok) begin
        addr_reg <= data_in;
      end
    end
  end

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic timeout_hit, drop_reg, drop_next;

  router_fsm_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .in_wait (state_reg == WAIT_TILL_EMPTY),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= drop_next;
    end
  end

  assign drop_pkt = drop_reg;
`else
  assign drop_pkt = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
`ifdef ROUTER_FSM_TIMEOUT_EN
    drop_next  = 1'b0;
`endif
    // A destination read-timeout kills the packet in flight regardless of progress.
    if (state_reg != DECODE_ADDRESS && soft_rst[addr_reg]) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state_reg)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok) begin
            state_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          // Full is checked first so the byte on the bus is held, not written.
          if (fifo_full) begin
            state_next = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_next = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_next = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            state_next = LOAD_PARITY;
          end else begin
            state_next = LOAD_DATA;
          end
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (fifo_empty[addr_reg]) begin
            state_next = LOAD_FIRST_DATA;
          end
`ifdef ROUTER_FSM_TIMEOUT_EN
          else if (timeout_hit) begin
            state_next = DECODE_ADDRESS;
            drop_next  = 1'b1;
          end
`endif
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_add    = (state_reg == DECODE_ADDRESS);
  assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
  assign ld_state      = (state_reg == LOAD_DATA);
  assign laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign full_state    = (state_reg == FIFO_FULL_STATE);
  assign busy          = (state_reg != DECODE_ADDRESS) && (state_reg != LOAD_DATA);
  assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY) ||
                         (state_reg == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: vector table, corner sequences, random vs. reference model.
module tb_router_fsm_ctrl;

  typedef enum int {T_DEC, T_LFD, T_LD, T_LP, T_FF, T_LAF, T_WT, T_CPE} tstate_e;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       pd;
    logic       lpv;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    tstate_e    exp;
  } vec_t;

  localparam int NP      = 3;
  localparam int TIMEOUT = 30;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0, fifo_full = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic [2:0] fifo_empty = 3'b111, soft_rst = 3'b000;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, drop_pkt;

  int n_checks = 0;
  int n_fail   = 0;

  tstate_e m_st   = T_DEC;
  int      m_addr = 0;
  int      m_wait = 0;
  bit      m_drop = 1'b0;

  vec_t vecs[$];

  router_fsm_ctrl dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_rst(soft_rst), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
    .drop_pkt(drop_pkt)
  );

  always #5 clk = ~clk;

  // Expected output word {detect,lfd,ld,laf,full,busy,wen,rst_int,drop} for a phase.
  function automatic logic [8:0] outs_of(tstate_e s, bit drop);
    logic b, w;
    b = !(s == T_DEC || s == T_LD);
    w = (s == T_LD || s == T_LP || s == T_LAF);
    return {s == T_DEC, s == T_LFD, s == T_LD, s == T_LAF, s == T_FF, b, w, s == T_CPE, drop};
  endfunction

  // Reference: applies the packet rules to the model at one clock edge.
  task automatic model_step();
    tstate_e nx;
    bit      dr;
    nx = m_st;
    dr = 1'b0;
    if (!rst) begin
      nx = T_DEC;
      m_addr = 0;
      m_wait = 0;
    end else if (m_st != T_DEC && soft_rst[m_addr]) begin
      nx = T_DEC;
    end else begin
      case (m_st)
        T_DEC: if (pkt_valid && int'(data_in) < NP) begin
          m_addr = int'(data_in);
          nx = fifo_empty[m_addr] ? T_LFD : T_WT;
        end
        T_LFD: nx = T_LD;
        T_LD:  if (fifo_full) nx = T_FF; else if (!pkt_valid) nx = T_LP;
        T_FF:  if (!fifo_full) nx = T_LAF;
        T_LAF: nx = parity_done ? T_DEC : (low_pkt_valid ? T_LP : T_LD);
        T_LP:  nx = T_CPE;
        T_CPE: nx = fifo_full ? T_FF : T_DEC;
        T_WT: begin
          if (fifo_empty[m_addr]) nx = T_LFD;
          else if (TMO_EN && m_wait == TIMEOUT - 1) begin
            nx = T_DEC;
            dr = 1'b1;
          end else m_wait++;
        end
        default: nx = T_DEC;
      endcase
      if (nx == T_WT && m_st != T_WT) m_wait = 0;
    end
    m_st   = nx;
    m_drop = dr;
  endtask

  task automatic check(string name, tstate_e es, bit ed);
    logic [8:0] got, exp;
    got = {detect_add, lfd_state, ld_state, laf_state, full_state, busy,
           write_enb_reg, rst_int_reg, drop_pkt};
    exp = outs_of(es, ed);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, required %b (dadd,lfd,ld,laf,full,busy,wen,rint,drop)",
               name, got, exp);
    end else begin
      $display("ok   %s: outputs %b", name, got);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic pd,
                       input logic lpv, input logic ff, input logic [2:0] fe,
                       input logic [2:0] sr);
    pkt_valid = pv; data_in = din; parity_done = pd;
    low_pkt_valid = lpv; fifo_full = ff; fifo_empty = fe; soft_rst = sr;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic vec_t v(logic pv, logic [1:0] din, logic pd, logic lpv, logic ff,
                             tstate_e e);
    vec_t r;
    r.pv = pv; r.din = din; r.pd = pd; r.lpv = lpv; r.ff = ff;
    r.fe = 3'b111; r.sr = 3'b000; r.exp = e;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    // Normal packet, addr 1: LFD, 3x LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE
    vecs.push_back(v(H, 2'd1, L, L, L, T_LFD));
    vecs.push_back(v(H, 2'd1, L, L, L, T_LD));
    vecs.push_back(v(H, 2'd1, L, L, L, T_LD));
    vecs.push_back(v(H, 2'd1, L, L, L, T_LD));
    vecs.push_back(v(L, 2'd1, L, L, L, T_LP));
    vecs.push_back(v(L, 2'd1, L, L, L, T_CPE));
    vecs.push_back(v(L, 2'd1, L, L, L, T_DEC));
    // Full during payload, release with pkt_valid high, then full at parity check
    vecs.push_back(v(H, 2'd0, L, L, L, T_LFD));
    vecs.push_back(v(H, 2'd0, L, L, L, T_LD));
    vecs.push_back(v(H, 2'd0, L, L, H, T_FF));
    vecs.push_back(v(H, 2'd0, L, L, H, T_FF));
    vecs.push_back(v(H, 2'd0, L, L, L, T_LAF));
    vecs.push_back(v(H, 2'd0, L, L, L, T_LD));
    vecs.push_back(v(L, 2'd0, L, L, L, T_LP));
    vecs.push_back(v(L, 2'd0, L, L, L, T_CPE));
    vecs.push_back(v(L, 2'd0, L, L, H, T_FF));
    vecs.push_back(v(L, 2'd0, L, L, L, T_LAF));
    vecs.push_back(v(L, 2'd0, H, L, L, T_DEC));
    // Address 3 ignored
    vecs.push_back(v(H, 2'd3, L, L, L, T_DEC));
    vecs.push_back(v(H, 2'd3, L, L, L, T_DEC));
    // LOAD_AFTER_FULL with low_pkt_valid -> LOAD_PARITY
    vecs.push_back(v(H, 2'd2, L, L, L, T_LFD));
    vecs.push_back(v(H, 2'd2, L, L, L, T_LD));
    vecs.push_back(v(H, 2'd2, L, L, H, T_FF));
    vecs.push_back(v(L, 2'd2, L, H, L, T_LAF));
    vecs.push_back(v(L, 2'd2, L, H, L, T_LP));
    vecs.push_back(v(L, 2'd2, L, L, L, T_CPE));
    vecs.push_back(v(L, 2'd2, L, L, L, T_DEC));
    // Full and !pkt_valid together in LOAD_DATA: full wins
    vecs.push_back(v(H, 2'd0, L, L, L, T_LFD));
    vecs.push_back(v(H, 2'd0, L, L, L, T_LD));
    vecs.push_back(v(L, 2'd0, L, L, H, T_FF));
    vecs.push_back(v(L, 2'd0, L, L, L, T_LAF));
    vecs.push_back(v(L, 2'd0, H, L, L, T_DEC));

    // Reset held for two cycles
    drive(L, 2'd0, L, L, L, 3'b111, 3'b000);
    rst = 1'b0;
    cyc();
    cyc();
    check("reset", T_DEC, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].din, vecs[i].pd, vecs[i].lpv, vecs[i].ff, vecs[i].fe, vecs[i].sr);
      cyc();
      check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

    // Busy destination: wait, then fifo_empty[2] rises at wait cycle 5
    drive(H, 2'd2, L, L, L, 3'b011, 3'b000);
    cyc();
    check("wait_enter", T_WT, 1'b0);
    drive(H, 2'd2, L, L, L, 3'b011, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("wait_hold%0d", k), T_WT, 1'b0);
    end
    drive(H, 2'd2, L, L, L, 3'b111, 3'b000);
    cyc();
    check("wait_release", T_LFD, 1'b0);
    cyc();
    check("wait_ld", T_LD, 1'b0);
    drive(L, 2'd0, L, L, L, 3'b111, 3'b000);
    cyc();
    cyc();
    cyc();
    check("wait_done", T_DEC, 1'b0);

    // Soft reset: only the bit of the latched address matters
    drive(H, 2'd1, L, L, L, 3'b111, 3'b000);
    cyc();
    cyc();
    check("srst_ld", T_LD, 1'b0);
    drive(H, 2'd1, L, L, L, 3'b111, 3'b001);
    cyc();
    check("srst_other", T_LD, 1'b0);
    drive(H, 2'd1, L, L, L, 3'b111, 3'b010);
    cyc();
    check("srst_own", T_DEC, 1'b0);
    drive(L, 2'd0, L, L, L, 3'b111, 3'b000);
    cyc();
    check("srst_idle", T_DEC, 1'b0);

    // Asynchronous reset mid-packet aborts without waiting for a clock
    drive(H, 2'd1, L, L, L, 3'b111, 3'b000);
    cyc();
    cyc();
    check("arst_pre", T_LD, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_now", T_DEC, 1'b0);
    cyc();
    check("arst_hold", T_DEC, 1'b0);
    rst = 1'b1;

    // Watchdog on a never-emptying destination
    drive(H, 2'd0, L, L, L, 3'b110, 3'b000);
    cyc();
    check("tmo_enter", T_WT, 1'b0);
    drive(L, 2'd0, L, L, L, 3'b110, 3'b000);
    if (TMO_EN) begin
      for (int k = 1; k < TIMEOUT; k++) begin
        cyc();
        check($sformatf("tmo_wait%0d", k), T_WT, 1'b0);
      end
      cyc();
      check("tmo_drop", T_DEC, 1'b1);
      cyc();
      check("tmo_after", T_DEC, 1'b0);
    end else begin
      for (int k = 1; k <= TIMEOUT + 5; k++) begin
        cyc();
        check($sformatf("tmo_wait%0d", k), T_WT, 1'b0);
      end
      drive(L, 2'd0, L, L, L, 3'b110, 3'b001);
      cyc();
      check("tmo_srst", T_DEC, 1'b0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      rst           = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      pkt_valid     = ($urandom_range(0, 99) < 75);
      data_in       = 2'($urandom);
      parity_done   = ($urandom_range(0, 99) < 30);
      low_pkt_valid = 1'($urandom);
      fifo_full     = ($urandom_range(0, 99) < 15);
      fifo_empty    = 3'($urandom) | 3'($urandom);
      soft_rst      = ($urandom_range(0, 99) < 4) ? 3'($urandom) : 3'b000;
      cyc();
      check($sformatf("rand%0d", n), m_st, m_drop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
